// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path: train payload and scheduler states.
package bp_pkg;

    localparam int BP_GH = 4;

    typedef struct packed {
        logic [31:0]      pc;
        logic             taken;
        logic [31:0]      target;
        logic [BP_GH-1:0] ghr;
    } bp_train_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        SETTLE  = 2'd2
    } bp_sched_state_e;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Resolver-side request bus plus predictor-side train/recover bus of the update scheduler.
interface bp_update_scheduler_if #(
    parameter int GH     = 4,
    parameter int NREQ   = 2,
    parameter int QDEPTH = 4
);
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*32-1:0]     req_pc_i;
    logic [NREQ-1:0]        req_taken_i;
    logic [NREQ*32-1:0]     req_target_i;
    logic [NREQ*GH-1:0]     req_ghr_i;
    logic                   mispredict_valid_i;
    logic                   mispredict_taken_i;
    logic [GH-1:0]          mispredict_ghr_i;
    logic                   train_valid_o;
    logic [31:0]            train_pc_o;
    logic                   train_actual_taken_o;
    logic [31:0]            train_actual_target_o;
    logic [GH-1:0]          train_ghr_snapshot_o;
    logic                   recover_mispredict_pulse_o;
    logic [GH-1:0]          recover_ghr_snapshot_o;
    logic                   predict_block_o;
    logic [$clog2(QDEPTH):0] queue_count_o;

    modport slave (
        input  req_valid_i, req_pc_i, req_taken_i, req_target_i, req_ghr_i,
        input  mispredict_valid_i, mispredict_taken_i, mispredict_ghr_i,
        output req_ready_o, train_valid_o, train_pc_o, train_actual_taken_o,
        output train_actual_target_o, train_ghr_snapshot_o,
        output recover_mispredict_pulse_o, recover_ghr_snapshot_o,
        output predict_block_o, queue_count_o
    );

    modport master (
        output req_valid_i, req_pc_i, req_taken_i, req_target_i, req_ghr_i,
        output mispredict_valid_i, mispredict_taken_i, mispredict_ghr_i,
        input  req_ready_o, train_valid_o, train_pc_o, train_actual_taken_o,
        input  train_actual_target_o, train_ghr_snapshot_o,
        input  recover_mispredict_pulse_o, recover_ghr_snapshot_o,
        input  predict_block_o, queue_count_o
    );

endinterface

// File: rtl/bp_train_fifo.sv
// Train-entry FIFO; head is readable combinationally, push and pop may coincide.
module bp_train_fifo
    import bp_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    push,
    input  logic                    pop,
    input  bp_train_t               wr_data,
    output bp_train_t               rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(QDEPTH):0] count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    bp_train_t       mem [QDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // storage carries no reset: occupancy alone decides what is valid
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Round-robin train arbitration into a queue, queue drain to the predictor, and mispredict recovery sequencing.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int GH     = BP_GH,
    parameter int NREQ   = 2,
    parameter int QDEPTH = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    bp_update_scheduler_if.slave  bus
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;

    bp_sched_state_e state;
    logic [RW-1:0]   rr;
    logic [RW-1:0]   grant;
    logic            any_valid;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    bp_train_t       wr_data;
    bp_train_t       head;

    logic            train_valid;
    bp_train_t       train_data;
    logic            recover_pulse;
    logic [GH-1:0]   recover_ghr;
    logic            predict_block;

    // first valid requester at or after the round-robin pointer
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_valid && bus.req_valid_i[idx]) begin
                any_valid = 1'b1;
                grant     = RW'(idx);
            end
        end
    end

    // full is taken from the registered count, so a same-cycle pop never frees a slot
    assign push = any_valid & ~full;
    assign pop  = (state == RUN) & ~empty;

    always_comb begin
        wr_data        = '0;
        wr_data.pc     = bus.req_pc_i[32*int'(grant) +: 32];
        wr_data.taken  = bus.req_taken_i[grant];
        wr_data.target = bus.req_target_i[32*int'(grant) +: 32];
        wr_data.ghr    = bus.req_ghr_i[GH*int'(grant) +: GH];
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (push) bus.req_ready_o[grant] = 1'b1;
    end

    bp_train_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= RUN;
            rr            <= '0;
            train_valid   <= 1'b0;
            train_data    <= '0;
            recover_pulse <= 1'b0;
            recover_ghr   <= '0;
            predict_block <= 1'b0;
        end else begin
            if (push) begin
                rr <= (int'(grant) == NREQ - 1) ? '0 : grant + RW'(1);
            end

            train_valid <= pop;
            if (pop) train_data <= head;

            // a new mispredict always restarts recovery, even mid-recovery
            if (bus.mispredict_valid_i) begin
                state         <= RECOVER;
                recover_pulse <= 1'b1;
                recover_ghr   <= {bus.mispredict_ghr_i[GH-2:0], bus.mispredict_taken_i};
                predict_block <= 1'b1;
            end else begin
                recover_pulse <= 1'b0;
                case (state)
                    RECOVER: begin
                        state         <= SETTLE;
                        predict_block <= 1'b1;
                    end
                    SETTLE: begin
                        state         <= RUN;
                        predict_block <= 1'b0;
                    end
                    default: begin
                        state         <= RUN;
                        predict_block <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.train_valid_o              = train_valid;
    assign bus.train_pc_o                 = train_data.pc;
    assign bus.train_actual_taken_o       = train_data.taken;
    assign bus.train_actual_target_o      = train_data.target;
    assign bus.train_ghr_snapshot_o       = train_data.ghr;
    assign bus.recover_mispredict_pulse_o = recover_pulse;
    assign bus.recover_ghr_snapshot_o     = recover_ghr;
    assign bus.predict_block_o            = predict_block;
    assign bus.queue_count_o              = count;

endmodule
